proc_fetch: RTL and testbench

- Fetch-stage datapath slice of the TinyRV1 five-stage pipeline (F, D, X, M, W).
- Holds the program counter and computes the next PC from the pipeline controller's pc select.
- Issues the instruction-memory request and captures the response and PC into the F/D pipeline register.
- Produces d2c_inst, the D-stage instruction the controller decodes for squash, stall and bypass decisions.

---
 rtl/proc_fetch.sv | 108 ++++++++++
 tb/tb_proc_fetch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/proc_fetch.sv
// proc_fetch: fetch-stage datapath slice of the TinyRV1 five-stage pipeline.
// Holds pc_F, selects the next PC from the controller's pc select, issues
// the instruction-memory request and captures the response and PC into the
// F/D pipeline register. No FSM; the controller owns validity (val_D).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   c2d_reg_en_F        PC register enable (0 = stall F)
//   c2d_pc_sel_F        next PC: 0 pc_F+4, 1 btarg_X, 2 jtarg_D, 3 jr_targ_D
//   c2d_reg_en_D        F/D register enable (0 = stall D)
//   c2d_imemreq_val     controller fetch request valid
//   btarg_X, jtarg_D, jr_targ_D   redirect targets
//   imemreq_val/addr    instruction-memory request
//   imemresp_data       same-cycle combinational read of imemreq_addr
//   d2c_inst, pc_D, pc_plus4_D    D-stage instruction, PC and link value
//
// Optional build macro PROC_FETCH_PERF_EN adds perf_fetch_cnt and
// perf_redirect_cnt, 32-bit saturating event counters.
module proc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000200,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c2d_reg_en_F,
  input  logic [1:0]  c2d_pc_sel_F,
  input  logic        c2d_reg_en_D,
  input  logic        c2d_imemreq_val,
  input  logic [31:0] btarg_X,
  input  logic [31:0] jtarg_D,
  input  logic [31:0] jr_targ_D,
  output logic        imemreq_val,
  output logic [31:0] imemreq_addr,
  input  logic [31:0] imemresp_data,
  output logic [31:0] d2c_inst,
  output logic [31:0] pc_D,
`ifdef PROC_FETCH_PERF_EN
  output logic [31:0] pc_plus4_D,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt
`else
  output logic [31:0] pc_plus4_D
`endif
);

  logic [31:0] pc_F;
  logic [31:0] pc_next;
  logic [31:0] inst_D;
  logic [31:0] pc_D_q;

  always_comb begin
    pc_next = pc_F + 32'd4;
    unique case (c2d_pc_sel_F)
      2'd0: pc_next = pc_F + 32'd4;
      2'd1: pc_next = btarg_X;
      2'd2: pc_next = jtarg_D;
      2'd3: pc_next = {jr_targ_D[31:2], 2'b00};
      default: pc_next = pc_F + 32'd4;
    endcase
  end

  // A redirect arriving while F is stalled is dropped; the controller re-presents it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_F <= RESET_PC;
    end else if (c2d_reg_en_F) begin
      pc_F <= pc_next;
    end
  end

  // F/D capture ignores imemreq_val; squashed words are masked by val_D upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_D <= NOP_INST;
      pc_D_q <= RESET_PC;
    end else if (c2d_reg_en_D) begin
      inst_D <= imemresp_data;
      pc_D_q <= pc_F;
    end
  end

  assign imemreq_addr = pc_F;
  assign imemreq_val  = c2d_imemreq_val & ~rst;
  assign d2c_inst     = inst_D;
  assign pc_D         = pc_D_q;
  assign pc_plus4_D   = pc_D_q + 32'd4;

`ifdef PROC_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (imemreq_val && c2d_reg_en_F && (fetch_cnt != '1))
        fetch_cnt <= fetch_cnt + 32'd1;
      if (c2d_reg_en_F && (c2d_pc_sel_F != 2'd0) && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt;
  assign perf_redirect_cnt = redirect_cnt;
`endif

endmodule

// File: tb/tb_proc_fetch.sv
// Directed testbench for proc_fetch. Instruction memory is modelled as
// addr ^ 32'hA5A5A5A5 so every fetched word identifies its address.
module tb_proc_fetch;

  localparam logic [31:0] K   = 32'hA5A5A5A5;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        c2d_reg_en_F;
  logic [1:0]  c2d_pc_sel_F;
  logic        c2d_reg_en_D;
  logic        c2d_imemreq_val;
  logic [31:0] btarg_X, jtarg_D, jr_targ_D;
  logic        imemreq_val;
  logic [31:0] imemreq_addr, imemresp_data, d2c_inst, pc_D, pc_plus4_D;
`ifdef PROC_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  assign imemresp_data = imemreq_addr ^ K;

  proc_fetch #(.RESET_PC(32'h00000200), .NOP_INST(32'h00000013)) dut (
    .clk             (clk),
    .rst             (rst),
    .c2d_reg_en_F    (c2d_reg_en_F),
    .c2d_pc_sel_F    (c2d_pc_sel_F),
    .c2d_reg_en_D    (c2d_reg_en_D),
    .c2d_imemreq_val (c2d_imemreq_val),
    .btarg_X         (btarg_X),
    .jtarg_D         (jtarg_D),
    .jr_targ_D       (jr_targ_D),
    .imemreq_val     (imemreq_val),
    .imemreq_addr    (imemreq_addr),
    .imemresp_data   (imemresp_data),
    .d2c_inst        (d2c_inst),
    .pc_D            (pc_D),
`ifdef PROC_FETCH_PERF_EN
    .pc_plus4_D      (pc_plus4_D),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
`else
    .pc_plus4_D      (pc_plus4_D)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr,
                             input logic [31:0] inst, input logic [31:0] pcd);
    check({tag, ".addr"}, imemreq_addr, addr);
    check({tag, ".inst"}, d2c_inst, inst);
    check({tag, ".pc_D"}, pc_D, pcd);
  endtask

  initial begin
    rst = 1'b1; c2d_reg_en_F = 1'b1; c2d_reg_en_D = 1'b1; c2d_pc_sel_F = 2'd0;
    c2d_imemreq_val = 1'b1; btarg_X = '0; jtarg_D = '0; jr_targ_D = '0;
    #1;
    check("val_in_rst", {31'd0, imemreq_val}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_state("reset", 32'h200, NOP, 32'h200);
    check("reset.pc4", pc_plus4_D, 32'h204);
    check("val_after_rst", {31'd0, imemreq_val}, 32'd1);

    // sequential fetch
    step(); check_state("seq1", 32'h204, 32'h200 ^ K, 32'h200);
    check("seq1.pc4", pc_plus4_D, 32'h204);
    step(); check_state("seq2", 32'h208, 32'h204 ^ K, 32'h204);

    // stall two cycles
    c2d_reg_en_F = 1'b0; c2d_reg_en_D = 1'b0;
    step(); check_state("stall1", 32'h208, 32'h204 ^ K, 32'h204);
    step(); check_state("stall2", 32'h208, 32'h204 ^ K, 32'h204);
    c2d_reg_en_F = 1'b1; c2d_reg_en_D = 1'b1;
    step(); check_state("resume", 32'h20C, 32'h208 ^ K, 32'h208);

    // branch redirect: wrong-path word still captured into D
    c2d_pc_sel_F = 2'd1; btarg_X = 32'h300;
    step(); check_state("br", 32'h300, 32'h20C ^ K, 32'h20C);
    // JR with low bits forced to zero
    c2d_pc_sel_F = 2'd3; jr_targ_D = 32'h403;
    step(); check_state("jr", 32'h400, 32'h300 ^ K, 32'h300);
    // redirect while F stalled is dropped, D still advances
    c2d_pc_sel_F = 2'd1; btarg_X = 32'h500; c2d_reg_en_F = 1'b0;
    step(); check_state("br_stallF", 32'h400, 32'h400 ^ K, 32'h400);
    c2d_reg_en_F = 1'b1;

    // wrap
    c2d_pc_sel_F = 2'd2; jtarg_D = 32'hFFFFFFFC;
    step(); check("jal.addr", imemreq_addr, 32'hFFFFFFFC);
    c2d_pc_sel_F = 2'd0;
    step(); check_state("wrap", 32'h00000000, 32'hFFFFFFFC ^ K, 32'hFFFFFFFC);
    check("wrap.pc4", pc_plus4_D, 32'h00000000);

    // reset mid-run
    c2d_pc_sel_F = 2'd1; btarg_X = 32'h340;
    step(); check("pre_rst.addr", imemreq_addr, 32'h340);
    c2d_pc_sel_F = 2'd0; rst = 1'b1;
    #1; check("mid_rst.val", {31'd0, imemreq_val}, 32'd0);
    step(); rst = 1'b0;
    #1; check_state("post_rst", 32'h200, NOP, 32'h200);

`ifdef PROC_FETCH_PERF_EN
    // counters were cleared by the reset edge; 5 sequential + 2 redirects
    for (int i = 0; i < 5; i++) step();
    c2d_pc_sel_F = 2'd1; btarg_X = 32'h600;
    step();
    c2d_pc_sel_F = 2'd2; jtarg_D = 32'h700;
    step();
    c2d_pc_sel_F = 2'd0;
    #1;
    check("perf_fetch", perf_fetch_cnt, 32'd7);
    check("perf_redirect", perf_redirect_cnt, 32'd2);
    // F stalled: neither counter moves
    c2d_reg_en_F = 1'b0; c2d_pc_sel_F = 2'd1;
    step();
    check("perf_fetch_stall", perf_fetch_cnt, 32'd7);
    check("perf_redirect_stall", perf_redirect_cnt, 32'd2);
    c2d_reg_en_F = 1'b1; c2d_pc_sel_F = 2'd0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
